// File: rtl/ir_queue_decoder.sv
// Instruction register with prefetch FIFO and one-hot opcode decoder.
// It supports a HALT state with resume, illegal-opcode flagging and flush.
module ir_queue_decoder #(
  parameter int DATA_W  = 8,
  parameter int OPC_W   = 3,
  parameter int NUM_OPS = 7,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         instr_in,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic                      flush,
  input  logic                      next,
  input  logic                      resume,
  output logic                      dec_valid,
  output logic [NUM_OPS-1:0]        op_onehot,
  output logic [DATA_W-OPC_W-1:0]   operand,
  output logic                      illegal,
  output logic                      halted,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [OPC_W-1:0] HALT_OPC = OPC_W'(NUM_OPS - 1);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] head;
  logic              push, pop, halt_now, retire;

  function automatic logic [NUM_OPS-1:0] decode(input logic [OPC_W-1:0] opc);
    logic [NUM_OPS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_OPS; k++) v[k] = (opc == OPC_W'(k));
    return v;
  endfunction

  assign head        = mem[rd_ptr];
  assign instr_ready = (level < LVL_W'(DEPTH));
  assign push        = instr_valid && instr_ready && !flush;
  assign halt_now    = (state == RUN) && dec_valid && next && (ir[OPC_W-1:0] == HALT_OPC);
  // The halting cycle must not reload the IR, so it blocks the pop.
  assign pop         = (state == RUN) && (level != '0) && (!dec_valid || next) && !halt_now;
  assign retire      = (state == RUN) && dec_valid && next;
  assign operand     = ir[DATA_W-1:OPC_W];
  assign halted      = (state == HALTED);

  // NOTE: FIFO storage has no reset; pointers and level alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instr_in;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ir        <= '0;
      dec_valid <= 1'b0;
      op_onehot <= '0;
      illegal   <= 1'b0;
      state     <= RUN;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      dec_valid <= 1'b0;
      op_onehot <= '0;
      illegal   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Decode alongside the IR load so the control vector lines up with the IR.
      if (pop) begin
        ir        <= head;
        dec_valid <= 1'b1;
        op_onehot <= decode(head[OPC_W-1:0]);
        illegal   <= (32'(head[OPC_W-1:0]) >= 32'(NUM_OPS));
      end else if (retire) begin
        dec_valid <= 1'b0;
        op_onehot <= '0;
        illegal   <= 1'b0;
      end

      if (halt_now)
        state <= HALTED;
      else if (state == HALTED && resume)
        state <= RUN;
    end
  end

endmodule

// File: tb/tb_ir_queue_decoder.sv
// Directed self-checking bench for ir_queue_decoder with default parameters.
module tb_ir_queue_decoder;

  logic       clk = 1'b0;
  logic       rst, instr_valid, flush, next, resume;
  logic [7:0] instr_in;
  logic       instr_ready, dec_valid, illegal, halted;
  logic [6:0] op_onehot;
  logic [4:0] operand;
  logic [2:0] level;

  int total = 0;
  int bad   = 0;

  ir_queue_decoder dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .next(next), .resume(resume),
    .dec_valid(dec_valid), .op_onehot(op_onehot), .operand(operand),
    .illegal(illegal), .halted(halted), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset(input string tag);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_dv"}, 32'(dec_valid), 0);
    check({tag, "_op"}, 32'(op_onehot), 0);
    check({tag, "_ill"}, 32'(illegal), 0);
    check({tag, "_halt"}, 32'(halted), 0);
    check({tag, "_rdy"}, 32'(instr_ready), 1);
    check({tag, "_opnd"}, 32'(operand), 0);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; flush = 1'b0; next = 1'b0; resume = 1'b0;
    instr_in = 8'h00;
    tick(); tick();
    rst = 1'b0;
    expect_reset("rst");

    // 1: stream with next held
    next = 1'b1; instr_valid = 1'b1; instr_in = 8'h01;
    tick();
    check("t1_dv0", 32'(dec_valid), 0);
    check("t1_lvl0", 32'(level), 1);
    instr_in = 8'h0A;
    tick();
    check("t1_dv1", 32'(dec_valid), 1);
    check("t1_add", 32'(op_onehot), 32'b0000010);
    check("t1_opnd0", 32'(operand), 0);
    instr_in = 8'h13;
    tick();
    check("t1_sub", 32'(op_onehot), 32'b0000100);
    check("t1_opnd1", 32'(operand), 1);
    check("t1_ill", 32'(illegal), 0);
    instr_valid = 1'b0;
    tick();
    check("t1_and", 32'(op_onehot), 32'b0001000);
    check("t1_opnd2", 32'(operand), 2);
    check("t1_lvl", 32'(level), 0);
    tick();
    check("t1_retire", 32'(dec_valid), 0);
    check("t1_op_clr", 32'(op_onehot), 0);
    next = 1'b0;

    // 2: fill FIFO, sixth word refused
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr_in = 8'h21 + 8'(i);
      tick();
    end
    check("t2_lvl_full", 32'(level), 4);
    check("t2_rdy0", 32'(instr_ready), 0);
    check("t2_ir_first", 32'(op_onehot), 32'b0000010);
    check("t2_opnd", 32'(operand), 4);
    instr_in = 8'h26;
    tick();
    check("t2_sixth_lvl", 32'(level), 4);
    instr_valid = 1'b0; next = 1'b1;
    tick();
    check("t2_pop_lvl", 32'(level), 3);
    check("t2_pop_rdy", 32'(instr_ready), 1);
    check("t2_pop_sub", 32'(op_onehot), 32'b0000100);
    tick();
    check("t2_and", 32'(op_onehot), 32'b0001000);
    tick();
    check("t2_or", 32'(op_onehot), 32'b0010000);
    tick();
    check("t2_sto", 32'(op_onehot), 32'b0100000);
    check("t2_empty", 32'(level), 0);
    tick();
    check("t2_drained", 32'(dec_valid), 0);
    next = 1'b0;

    // 3: HALT then resume
    instr_valid = 1'b1; instr_in = 8'h06;
    tick();
    instr_in = 8'h00;
    tick();
    check("t3_halt_op", 32'(op_onehot), 32'b1000000);
    check("t3_lvl1", 32'(level), 1);
    instr_valid = 1'b0; next = 1'b1;
    tick();
    check("t3_halted", 32'(halted), 1);
    check("t3_dv0", 32'(dec_valid), 0);
    check("t3_lvl_keep", 32'(level), 1);
    check("t3_op0", 32'(op_onehot), 0);
    tick();
    check("t3_next_ign", 32'(dec_valid), 0);
    check("t3_next_lvl", 32'(level), 1);
    next = 1'b0; resume = 1'b1;
    tick();
    check("t3_run", 32'(halted), 0);
    check("t3_no_load_yet", 32'(dec_valid), 0);
    resume = 1'b0;
    tick();
    check("t3_ld_dv", 32'(dec_valid), 1);
    check("t3_ld_op", 32'(op_onehot), 32'b0000001);
    check("t3_ld_lvl", 32'(level), 0);
    next = 1'b1;
    tick();
    next = 1'b0;

    // 4: illegal opcode
    instr_valid = 1'b1; instr_in = 8'h07;
    tick();
    instr_in = 8'h0C;
    tick();
    instr_valid = 1'b0;
    check("t4_ill", 32'(illegal), 1);
    check("t4_op0", 32'(op_onehot), 0);
    check("t4_dv", 32'(dec_valid), 1);
    tick();
    check("t4_hold", 32'(illegal), 1);
    check("t4_run", 32'(halted), 0);
    check("t4_lvl", 32'(level), 1);
    next = 1'b1;
    tick();
    check("t4_after_ill", 32'(illegal), 0);
    check("t4_or", 32'(op_onehot), 32'b0010000);
    check("t4_opnd", 32'(operand), 1);
    tick();
    next = 1'b0;

    // 5: flush with coincident push
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_in = 8'h31 + 8'(i);
      tick();
    end
    check("t5_lvl3", 32'(level), 3);
    check("t5_dv1", 32'(dec_valid), 1);
    flush = 1'b1; instr_in = 8'h35;
    tick();
    flush = 1'b0; instr_valid = 1'b0;
    check("t5_lvl0", 32'(level), 0);
    check("t5_dv0", 32'(dec_valid), 0);
    check("t5_op0", 32'(op_onehot), 0);
    tick();
    check("t5_lost_lvl", 32'(level), 0);
    check("t5_lost_dv", 32'(dec_valid), 0);
    instr_valid = 1'b1; instr_in = 8'h02;
    tick();
    instr_valid = 1'b0;
    tick();
    check("t5_restart", 32'(op_onehot), 32'b0000100);
    next = 1'b1;
    tick();
    next = 1'b0;

    // 6: reset while halted
    instr_valid = 1'b1; instr_in = 8'h06;
    tick();
    instr_valid = 1'b0;
    tick();
    next = 1'b1;
    tick();
    next = 1'b0; instr_valid = 1'b1; instr_in = 8'h09;
    tick();
    instr_valid = 1'b0;
    check("t6_halted", 32'(halted), 1);
    check("t6_lvl", 32'(level), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_reset("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_queue_decoder.md
Name: ir_queue_decoder

Overview:
Parametrised instruction register and decoder for the CPU control path. It buffers fetched instruction bytes in a small prefetch FIFO and holds the current instruction in an IR stage. The IR opcode field is decoded into a one-hot control vector, which stays stable until the control unit acknowledges it. It adds illegal-opcode detection, a HALT state with resume, and flush; the earlier IR block had none of these.

Parameters:
DATA_W, 8, instruction word width
OPC_W, 3, opcode field width; opcode = instr[OPC_W-1:0]
NUM_OPS, 7, number of legal opcodes, i.e. one-hot width; requires NUM_OPS <= 2**OPC_W
DEPTH, 4, prefetch FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
instr_in  in  DATA_W  fetched instruction word
instr_valid  in  1  instr_in valid
instr_ready  out  1  FIFO can accept; equals (level < DEPTH)
flush  in  1  discard FIFO contents and current IR
next  in  1  control unit done with current instruction
resume  in  1  leave HALTED state
dec_valid  out  1  IR holds an undecoded-pending instruction
op_onehot  out  NUM_OPS  bit k = 1 iff opcode == k; bit 0 = LD, 1 = ADD, 2 = SUB, 3 = AND, 4 = OR, 5 = STO, NUM_OPS-1 = HALT
operand  out  DATA_W-OPC_W  instr[DATA_W-1:OPC_W] of the current IR
illegal  out  1  IR opcode >= NUM_OPS
halted  out  1  FSM in HALTED
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst = 1 at an edge) clears the following: FIFO pointers, level = 0, IR = 0, dec_valid = 0, op_onehot = 0, illegal = 0, halted = 0, state = RUN. instr_ready = 1 after reset.
- Priority at each edge: rst > flush > normal operation.
- Push: at an edge with instr_valid && instr_ready, instr_in is written at the write pointer. Pointers wrap modulo DEPTH.
- instr_ready does not depend on next or pop. There is no pass-through when full.
- IR load condition: state == RUN, FIFO non-empty, and (dec_valid == 0 or next == 1). On load, the FIFO head is moved into the IR, the FIFO is popped, and dec_valid = 1.
- Load latency: a word accepted at edge E appears in the IR after edge E+1, provided the IR was free. There is no FIFO bypass.
- Retire: next with dec_valid and no load clears dec_valid. next while dec_valid = 0 is ignored.
- Simultaneous push and pop in one cycle leaves level unchanged.
- Outputs op_onehot, illegal and operand are registered and derived from the IR. When dec_valid = 0, op_onehot = 0 and illegal = 0.
- An illegal opcode gives op_onehot = 0 and illegal = 1. It still requires next to be discarded. No state change.
- FSM has two states, RUN and HALTED:
  - RUN -> HALTED at an edge where next = 1 and the IR holds HALT. In that cycle dec_valid clears and no reload occurs.
  - While HALTED: halted = 1, no IR loads, next is ignored. Pushes continue until the FIFO is full.
  - HALTED -> RUN at an edge with resume = 1. Loading restarts from the following edge.
  - resume while in RUN is ignored.
- flush clears the FIFO (level = 0) and dec_valid; the FSM state is unchanged. A push coincident with flush is dropped.

Test Plan:
1. Reset then push 0x01, 0x0A, 0x13 on consecutive cycles with next held at 1 -> dec_valid from cycle 2. op_onehot sequence is 0000010 (ADD), 0000100 (SUB, operand 1), 0001000 (AND, operand 2). illegal = 0 throughout.
2. Push 5 words with next = 0 and DEPTH = 4 -> first word is in the IR; level reaches 4; instr_ready = 0; the 6th word is not accepted. Pulse next once -> level drops to 3 and instr_ready = 1.
3. Push 0x06 (HALT) then 0x00 (LD), and assert next on the HALT -> halted = 1 and dec_valid = 0; LD stays in the FIFO with level = 1. Assert resume -> LD appears in the IR two edges later with op_onehot = 0000001.
4. Push 0x07 -> illegal = 1 and op_onehot = 0; the FSM stays in RUN. Next pushed word decodes normally after next.
5. With level = 3 and dec_valid = 1, assert flush together with instr_valid -> level = 0, dec_valid = 0, and the pushed word is lost.
6. Assert rst mid-stream while halted -> all outputs return to reset values and halted = 0.
